// File: rtl/csa16_reg.sv
// 16-bit carry-select adder with a one-cycle registered output stage.
// Optional signed-overflow output ovf is enabled by defining CSA16_OVF_EN.
module csa16_reg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef CSA16_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NBLK = WIDTH / BLK;

  logic [WIDTH-1:0] sum_c;
  logic [NBLK:0]    bc;
`ifdef CSA16_OVF_EN
  logic [NBLK-1:0]  msb_c;
`endif

  assign bc[0] = cin;

  generate
    for (genvar k = 0; k < NBLK; k++) begin : g_blk
      if (k == 0) begin : g_rca
        logic [BLK:0] c;
        assign c[0] = bc[0];
        for (genvar i = 0; i < BLK; i++) begin : g_fa
          assign sum_c[i] = a[i] ^ b[i] ^ c[i];
          assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        assign bc[1] = c[BLK];
`ifdef CSA16_OVF_EN
        assign msb_c[0] = c[BLK-1];
`endif
      end else begin : g_sel
        logic [BLK:0]   c0, c1;
        logic [BLK-1:0] s0, s1;
        assign c0[0] = 1'b0;
        assign c1[0] = 1'b1;
        for (genvar i = 0; i < BLK; i++) begin : g_fa
          localparam int unsigned IDX = k * BLK + i;
          assign s0[i]   = a[IDX] ^ b[IDX] ^ c0[i];
          assign c0[i+1] = (a[IDX] & b[IDX]) | (c0[i] & (a[IDX] ^ b[IDX]));
          assign s1[i]   = a[IDX] ^ b[IDX] ^ c1[i];
          assign c1[i+1] = (a[IDX] & b[IDX]) | (c1[i] & (a[IDX] ^ b[IDX]));
        end
        // Conditional-operator muxes keep bits known where both candidates agree.
        assign sum_c[k*BLK +: BLK] = bc[k] ? s1 : s0;
        assign bc[k+1]             = bc[k] ? c1[BLK] : c0[BLK];
`ifdef CSA16_OVF_EN
        assign msb_c[k] = bc[k] ? c1[BLK-1] : c0[BLK-1];
`endif
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef CSA16_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_c;
        cout <= bc[NBLK];
`ifdef CSA16_OVF_EN
        ovf  <= msb_c[NBLK-1] ^ bc[NBLK];
`endif
      end
    end
  end

endmodule

// File: tb/tb_csa16_reg.sv
// Scoreboard bench for csa16_reg: stimulus pushes expected results, a monitor
// pops and compares whenever out_valid is seen, and checks hold on idle cycles.
module tb_csa16_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        out_valid;
`ifdef CSA16_OVF_EN
  logic        ovf;
`endif

  csa16_reg #(.WIDTH(16), .BLK(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .cout     (cout),
    .out_valid(out_valid)
`ifdef CSA16_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [15:0] mask;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp, input logic [15:0] mask);
    n_chk++;
    if (((act ^ exp) & mask) === 16'h0000) n_pass++;
    else $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, act, exp, mask, $time);
  endtask

  // Drive one cycle of inputs; valid transactions push their expected result.
  task automatic issue(input logic v, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic [15:0] es, input logic ec,
                       input logic eo, input logic [15:0] em);
    exp_t e;
    in_valid = v;
    a = ia;
    b = ib;
    cin = ic;
    if (v) begin
      e.sum = es; e.cout = ec; e.ovf = eo; e.mask = em;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    logic        r;
    logic [15:0] hold_sum;
    logic        hold_cout;
    logic        hold_ovf;
    logic [15:0] hold_mask;
    exp_t        e;
    hold_sum = '0; hold_cout = 1'b0; hold_ovf = 1'b0; hold_mask = '1;
    forever begin
      @(posedge clk);
      r = rst;
      @(negedge clk);
      if (r) begin
        hold_sum = '0; hold_cout = 1'b0; hold_ovf = 1'b0; hold_mask = '1;
      end
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", {15'd0, out_valid}, 16'd0, 16'hFFFF);
        end else begin
          e = q.pop_front();
          check("sum", sum, e.sum, e.mask);
          check("cout", {15'd0, cout}, {15'd0, e.cout}, 16'hFFFF);
`ifdef CSA16_OVF_EN
          check("ovf", {15'd0, ovf}, {15'd0, e.ovf}, 16'hFFFF);
`endif
          hold_sum = e.sum; hold_cout = e.cout; hold_ovf = e.ovf; hold_mask = e.mask;
        end
      end else begin
        check("out_valid_low", {15'd0, out_valid}, 16'd0, 16'hFFFF);
        check("hold_sum", sum, hold_sum, hold_mask);
        check("hold_cout", {15'd0, cout}, {15'd0, hold_cout}, 16'hFFFF);
`ifdef CSA16_OVF_EN
        check("hold_ovf", {15'd0, ovf}, {15'd0, hold_ovf}, 16'hFFFF);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    logic [16:0] r17;
    rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_sum", sum, 16'h0000, 16'hFFFF);
      check("rst_cout", {15'd0, cout}, 16'd0, 16'hFFFF);
      check("rst_out_valid", {15'd0, out_valid}, 16'd0, 16'hFFFF);
    end
    rst = 1'b0;
    issue(1, 16'h1234, 16'h1111, 0, 16'h2345, 0, 0, 16'hFFFF);

    issue(1, 16'd5, 16'd3, 1, 16'd9, 0, 0, 16'hFFFF);
    issue(1, 16'd5, 16'd3, 0, 16'd8, 0, 0, 16'hFFFF);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int c = 0; c < 2; c++) begin
          r17 = 17'(i + j + c);
          issue(1, 16'(i), 16'(j), c[0], r17[15:0], 1'b0, 1'b0, 16'hFFFF);
        end

    issue(1, 16'hFFFF, 16'h0000, 1, 16'h0000, 1, 0, 16'hFFFF);
    issue(1, 16'h8000, 16'h8000, 0, 16'h0000, 1, 1, 16'hFFFF);
    issue(1, 16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1, 0, 16'hFFFF);
    issue(1, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 16'hFFFF);
    issue(1, 16'h0FFF, 16'h0001, 0, 16'h1000, 0, 0, 16'hFFFF);

    // Unknown carry-in: only the low nibble may depend on it.
    issue(1, 16'h0003, 16'h0004, 1'bx, 16'h0000, 0, 0, 16'hFFF0);
    issue(1, 16'h0003, 16'h0004, 1, 16'h0008, 0, 0, 16'hFFFF);

    issue(1, 16'h1111, 16'h2222, 0, 16'h3333, 0, 0, 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      issue(1, 16'h00F0, 16'h0010, 0, 16'h0100, 0, 0, 16'hFFFF);
      issue(0, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 0, 0, 16'hFFFF);
    end
    issue(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'hFFFF);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 16'(q.size()), 16'd0, 16'hFFFF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
